// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full -- write-domain pointer / full-flag stage of the async FIFO.
//
// Turns write requests into RAM write enables and addresses, and exports a
// Gray-coded write pointer to the read domain. The read domain's Gray pointer
// is brought in through a two-flop synchroniser. The full flag, fill level
// and sticky overflow flag are derived from that synchronised pointer.
//
// Optional build macro: FIFO_WPTR_AFULL_EN adds the registered walmost_full
// output (fill level >= AFULL_THRESH).
//
// Ports:
//   clk              in   write clock
//   rst              in   asynchronous, active-high reset
//   winc             in   write request
//   rptr_gray_async  in   read-domain Gray pointer (asynchronous to clk)
//   wen              out  write accept (winc & ~wfull), RAM write enable
//   waddr            out  RAM write address
//   wptr_gray        out  registered Gray write pointer to the read domain
//   wfull            out  registered full flag
//   wcount           out  registered fill level, 0..2**ADDR_W
//   wr_overflow      out  sticky: a write was attempted while full
//   walmost_full     out  registered almost-full (FIFO_WPTR_AFULL_EN only)
module fifo_wptr_full #(
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [ADDR_W:0]   rptr_gray_async,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              wfull,
  output logic [ADDR_W:0]   wcount,
`ifdef FIFO_WPTR_AFULL_EN
  output logic              walmost_full,
`endif
  output logic              wr_overflow
);

  localparam logic [ADDR_W:0] AFULL_TH = AFULL_THRESH[ADDR_W:0];

  logic [ADDR_W:0] wbin_q, wbin_d;
  logic [ADDR_W:0] wptr_gray_q, wptr_gray_d;
  logic [ADDR_W:0] rq1_q, rq1_d;
  logic [ADDR_W:0] rq2_q, rq2_d;
  logic [ADDR_W:0] wcount_q, wcount_d;
  logic            wfull_q, wfull_d;
  logic            wr_overflow_q, wr_overflow_d;
  logic [ADDR_W:0] rbin;

  // Accept decision uses only the registered full flag; since wfull only
  // clears after the read pointer has been synchronised, it is conservative.
  assign wen   = winc & ~wfull_q;
  assign waddr = wbin_q[ADDR_W-1:0];

  always_comb begin
    rbin = '0;
    // Gray -> binary: each bit is the XOR of all Gray bits at or above it.
    for (int i = 0; i <= ADDR_W; i++) rbin[i] = ^(rq2_q >> i);

    rq1_d         = rptr_gray_async;
    rq2_d         = rq1_q;
    wbin_d        = wbin_q + {{ADDR_W{1'b0}}, wen};
    wptr_gray_d   = wbin_d ^ (wbin_d >> 1);
    // Full when the next write pointer has lapped the read pointer: top two
    // Gray bits inverted, the rest equal.
    wfull_d       = (wptr_gray_d == {~rq2_q[ADDR_W:ADDR_W-1], rq2_q[ADDR_W-2:0]});
    wcount_d      = wbin_d - rbin;
    wr_overflow_d = wr_overflow_q | (winc & wfull_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q        <= '0;
      wptr_gray_q   <= '0;
      rq1_q         <= '0;
      rq2_q         <= '0;
      wfull_q       <= 1'b0;
      wcount_q      <= '0;
      wr_overflow_q <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      wptr_gray_q   <= wptr_gray_d;
      rq1_q         <= rq1_d;
      rq2_q         <= rq2_d;
      wfull_q       <= wfull_d;
      wcount_q      <= wcount_d;
      wr_overflow_q <= wr_overflow_d;
    end
  end

  assign wptr_gray   = wptr_gray_q;
  assign wfull       = wfull_q;
  assign wcount      = wcount_q;
  assign wr_overflow = wr_overflow_q;

`ifdef FIFO_WPTR_AFULL_EN
  logic walmost_full_q, walmost_full_d;

  always_comb begin
    walmost_full_d = (wcount_d >= AFULL_TH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) walmost_full_q <= 1'b0;
    else     walmost_full_q <= walmost_full_d;
  end

  assign walmost_full = walmost_full_q;
`else
  logic unused_afull;
  assign unused_afull = ^AFULL_TH;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (ADDR_W=4): reset, fill to full,
// overflow, full release after a read-pointer change, pointer wrap, and
// almost-full when FIFO_WPTR_AFULL_EN is defined.
module tb_fifo_wptr_full;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              winc;
  logic [ADDR_W:0]   rptr_gray_async;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wptr_gray;
  logic              wfull;
  logic [ADDR_W:0]   wcount;
  logic              wr_overflow;
`ifdef FIFO_WPTR_AFULL_EN
  logic              walmost_full;
`endif

  int checks = 0;
  int errors = 0;

  fifo_wptr_full #(.ADDR_W(ADDR_W), .AFULL_THRESH(12)) dut (
    .clk             (clk),
    .rst             (rst),
    .winc            (winc),
    .rptr_gray_async (rptr_gray_async),
    .wen             (wen),
    .waddr           (waddr),
    .wptr_gray       (wptr_gray),
    .wfull           (wfull),
    .wcount          (wcount),
`ifdef FIFO_WPTR_AFULL_EN
    .walmost_full    (walmost_full),
`endif
    .wr_overflow     (wr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gray(input int b);
    logic [31:0] v;
    v = b & 31;
    return v ^ (v >> 1);
  endfunction

  initial begin
    rst = 1'b1; winc = 1'b0; rptr_gray_async = '0;
    #12;
    check("rst_gray",  32'(wptr_gray), 0);
    check("rst_waddr", 32'(waddr), 0);
    check("rst_full",  32'(wfull), 0);
    check("rst_count", 32'(wcount), 0);
    check("rst_ovf",   32'(wr_overflow), 0);
    rst = 1'b0;

    // Seven writes, then reset between edges.
    step();
    winc = 1'b1;
    repeat (7) step();
    check("pre_rst_waddr", 32'(waddr), 7);
    check("pre_rst_gray",  32'(wptr_gray), 32'h04);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_gray",  32'(wptr_gray), 0);
    check("mid_rst_waddr", 32'(waddr), 0);
    check("mid_rst_full",  32'(wfull), 0);
    check("mid_rst_count", 32'(wcount), 0);
    check("mid_rst_ovf",   32'(wr_overflow), 0);
    check("mid_rst_wen",   32'(wen), 1);
    rst = 1'b0;

    // Fill 16 slots with the read pointer parked at 0.
    for (int i = 1; i <= 16; i++) begin
      check("fill_wen", 32'(wen), 1);
      step();
      check("fill_gray",  32'(wptr_gray), gray(i));
      check("fill_waddr", 32'(waddr), i % 16);
      check("fill_count", 32'(wcount), i);
      check("fill_full",  32'(wfull), (i == 16) ? 1 : 0);
    end
    check("full_gray_11000", 32'(wptr_gray), 32'h18);

    // Writes while full are dropped and flag overflow.
    for (int i = 0; i < 3; i++) begin
      check("ovf_wen", 32'(wen), 0);
      step();
      check("ovf_waddr", 32'(waddr), 0);
      check("ovf_gray",  32'(wptr_gray), 32'h18);
      check("ovf_flag",  32'(wr_overflow), 1);
      check("ovf_count", 32'(wcount), 16);
    end
    winc = 1'b0;
    step();
    check("ovf_sticky", 32'(wr_overflow), 1);

    // One read: full holds for two edges, clears on the third.
    rptr_gray_async = 5'b00001;
    step(); check("rel_full_e1", 32'(wfull), 1);
    step(); check("rel_full_e2", 32'(wfull), 1);
    step(); check("rel_full_e3", 32'(wfull), 0);
    check("rel_count", 32'(wcount), 15);

    // Wrap: 32 writes with the read pointer trailing.
    rst = 1'b1; #1 rst = 1'b0;
    winc = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      rptr_gray_async = 5'(gray((n - 1 >= 12) ? n - 1 - 12 : 0));
      step();
      check("wrap_gray",  32'(wptr_gray), gray(n));
      check("wrap_waddr", 32'(waddr), n % 16);
      check("wrap_full",  32'(wfull), 0);
      check("wrap_count", 32'(wcount), (n < 15) ? n : 15);
      if (n == 31) check("wrap_gray_31", 32'(wptr_gray), 32'h10);
    end
    check("wrap_gray_0", 32'(wptr_gray), 0);
    winc = 1'b0;

`ifdef FIFO_WPTR_AFULL_EN
    rst = 1'b1; #1 rst = 1'b0;
    rptr_gray_async = '0;
    winc = 1'b1;
    repeat (11) step();
    check("afull_11", 32'(walmost_full), 0);
    step();
    check("afull_12", 32'(walmost_full), 1);
    check("afull_nofull", 32'(wfull), 0);
    winc = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
